// File: rtl/ps2_pkg.sv
// Shared PS/2 front-end constants: idle line level and default synchroniser/filter depths.
// Also used by the frame shifter so both ends agree on timing defaults.
package ps2_pkg;

   localparam logic PS2_IDLE_LEVEL      = 1'b1;
   localparam int   PS2_SYNC_STAGES_DEF = 2;
   localparam int   PS2_FILTER_LEN_DEF  = 8;

   // Counter width able to hold 0..len-1; never narrower than one bit.
   function automatic int ps2_cnt_width(input int len);
      return (len > 1) ? $clog2(len) : 1;
   endfunction

endpackage

// File: rtl/ps2_valid_one_shot.sv
// Turns the level isValid flag into a one-cycle Valid strobe on each sampled 0->1 rise.
// Latency: strobe registered one edge after the first high sample; no backpressure.
module ps2_valid_one_shot
   import ps2_pkg::*;
(
   input  logic Clock,
   input  logic Reset,
   input  logic isValid,
   output logic Valid
);

   logic history;

   // History resets high so a flag already high at reset release is not reported.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         history <= 1'b1;
         Valid   <= 1'b0;
      end else begin
         history <= isValid;
         Valid   <= isValid & ~history;
      end
   end

endmodule

// File: rtl/ps2_edge_pulse.sv
// Synchronises and glitch-filters PS2Clock, emitting registered one-cycle edge strobes.
// Latency: SYNC_STAGES+FILTER_LEN edges from a clean line change; no backpressure.
module ps2_edge_pulse
   import ps2_pkg::*;
#(
   parameter int SYNC_STAGES = PS2_SYNC_STAGES_DEF,
   parameter int FILTER_LEN  = PS2_FILTER_LEN_DEF
) (
   input  logic Clock,
   input  logic Reset,
   input  logic PS2Clock,
   input  logic isValid,
   output logic FallingEdge,
   output logic RisingEdge,
   output logic Valid
);

   localparam int            CW       = ps2_cnt_width(FILTER_LEN);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   sync_out;
   logic                   filtered;
   logic                   mismatch;
   logic                   flip;
   logic [CW-1:0]          cnt;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         sync <= {SYNC_STAGES{PS2_IDLE_LEVEL}};
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], PS2Clock};
      end
   end

   assign sync_out = sync[SYNC_STAGES-1];
   assign mismatch = (sync_out != filtered);
   assign flip     = mismatch && (cnt == CNT_LAST);

   // Any agreeing sample restarts the count, so only an unbroken run can flip the level.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         filtered <= PS2_IDLE_LEVEL;
         cnt      <= '0;
      end else if (flip) begin
         filtered <= ~filtered;
         cnt      <= '0;
      end else if (mismatch) begin
         cnt      <= cnt + 1'b1;
      end else begin
         cnt      <= '0;
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         FallingEdge <= 1'b0;
         RisingEdge  <= 1'b0;
      end else begin
         FallingEdge <= flip &  filtered;
         RisingEdge  <= flip & ~filtered;
      end
   end

   ps2_valid_one_shot u_valid_one_shot (
      .Clock   (Clock),
      .Reset   (Reset),
      .isValid (isValid),
      .Valid   (Valid)
   );

endmodule

// File: tb/tb_ps2_edge_pulse.sv
// Directed bench for ps2_edge_pulse: a window-based behavioural model checked every cycle,
// plus literal pulse counts and latencies for each scenario.
module tb_ps2_edge_pulse;

   localparam int SS = 2;
   localparam int FL = 8;

   logic Clock;
   logic Reset;
   logic PS2Clock;
   logic isValid;
   logic FallingEdge;
   logic RisingEdge;
   logic Valid;

   int checks = 0;
   int errors = 0;

   ps2_edge_pulse #(.SYNC_STAGES(SS), .FILTER_LEN(FL)) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .PS2Clock    (PS2Clock),
      .isValid     (isValid),
      .FallingEdge (FallingEdge),
      .RisingEdge  (RisingEdge),
      .Valid       (Valid)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Model state: raw samples taken at every edge since reset release.
   bit ps2_s[$];
   bit iv_s[$];
   int last_flip;
   bit filt_m, fall_m, rise_m, valid_m;

   // Per-run tallies.
   int f_cnt, r_cnt, v_cnt, first_f, first_r, first_v;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      ps2_s.delete();
      iv_s.delete();
      last_flip = -1000000;
      filt_m  = 1'b1;
      fall_m  = 1'b0;
      rise_m  = 1'b0;
      valid_m = 1'b0;
   endtask

   // Filter input seen at edge k is the raw line sampled SS edges earlier (idle before reset).
   function automatic bit filt_in(input int k);
      int idx;
      idx = k - SS;
      return (idx < 0) ? 1'b1 : ps2_s[idx];
   endfunction

   task automatic model_edge();
      int k;
      bit flip;
      if (!Reset) begin
         model_clear();
      end else begin
         ps2_s.push_back(PS2Clock);
         iv_s.push_back(isValid);
         k = ps2_s.size() - 1;
         // Level flips when the last FL inputs all disagree and none predates the last flip.
         flip = (k - FL + 1) > last_flip;
         for (int j = k - FL + 1; j <= k; j++)
            if (filt_in(j) == filt_m) flip = 1'b0;
         fall_m = flip && filt_m;
         rise_m = flip && !filt_m;
         if (flip) begin
            filt_m    = !filt_m;
            last_flip = k;
         end
         valid_m = iv_s[k] && !((k == 0) ? 1'b1 : iv_s[k-1]);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      model_edge();
      #1;
      chk("FallingEdge", int'(FallingEdge), int'(fall_m));
      chk("RisingEdge",  int'(RisingEdge),  int'(rise_m));
      chk("Valid",       int'(Valid),       int'(valid_m));
      chk("edges_exclusive", int'(FallingEdge & RisingEdge), 0);
   endtask

   task automatic run(input int n);
      f_cnt = 0; r_cnt = 0; v_cnt = 0;
      first_f = 0; first_r = 0; first_v = 0;
      for (int i = 1; i <= n; i++) begin
         step();
         if (FallingEdge) begin f_cnt++; if (first_f == 0) first_f = i; end
         if (RisingEdge)  begin r_cnt++; if (first_r == 0) first_r = i; end
         if (Valid)       begin v_cnt++; if (first_v == 0) first_v = i; end
      end
   endtask

   initial begin
      int toggles_v;
      model_clear();
      Reset    = 1'b0;
      PS2Clock = 1'b1;
      isValid  = 1'b0;

      // Reset then idle: nothing fires.
      run(3);
      Reset = 1'b1;
      run(20);
      chk("idle_fall_cnt", f_cnt, 0);
      chk("idle_rise_cnt", r_cnt, 0);
      chk("idle_valid_cnt", v_cnt, 0);

      // Clean falling then rising transition.
      PS2Clock = 1'b0;
      run(15);
      chk("clean_fall_cnt", f_cnt, 1);
      chk("clean_fall_lat", first_f, 10);
      chk("clean_fall_norise", r_cnt, 0);
      PS2Clock = 1'b1;
      run(15);
      chk("clean_rise_cnt", r_cnt, 1);
      chk("clean_rise_lat", first_r, 10);
      chk("clean_rise_nofall", f_cnt, 0);

      // Glitches of 3 and 7 cycles are swallowed.
      PS2Clock = 1'b0; run(3);
      PS2Clock = 1'b1; run(15);
      chk("glitch3_strobes", f_cnt + r_cnt, 0);
      PS2Clock = 1'b0; run(7);
      chk("glitch7_low_strobes", f_cnt + r_cnt, 0);
      PS2Clock = 1'b1; run(15);
      chk("glitch7_strobes", f_cnt + r_cnt, 0);

      // A 10-cycle low pulse passes.
      PS2Clock = 1'b0; run(10);
      chk("pulse10_fall_cnt", f_cnt, 1);
      chk("pulse10_fall_lat", first_f, 10);
      PS2Clock = 1'b1; run(15);
      chk("pulse10_rise_cnt", r_cnt, 1);
      chk("pulse10_rise_lat", first_r, 10);

      // isValid held high: one strobe; re-arm after a single low sample.
      isValid = 1'b1; run(50);
      chk("valid_hold_cnt", v_cnt, 1);
      chk("valid_hold_lat", first_v, 1);
      isValid = 1'b0; run(1);
      chk("valid_low_cnt", v_cnt, 0);
      isValid = 1'b1; run(5);
      chk("valid_rearm_cnt", v_cnt, 1);
      chk("valid_rearm_lat", first_v, 1);
      isValid = 1'b0; run(2);

      // Toggling every cycle: one strobe per high sample.
      toggles_v = 0;
      for (int i = 0; i < 6; i++) begin
         isValid = (i % 2 == 0);
         run(1);
         toggles_v += v_cnt;
      end
      chk("valid_toggle_cnt", toggles_v, 3);

      // isValid high across reset: no strobe until seen low.
      isValid = 1'b1; run(2);
      Reset = 1'b0;
      #1;
      chk("async_valid_clear", int'(Valid), 0);
      run(3);
      Reset = 1'b1;
      run(10);
      chk("valid_thru_reset_cnt", v_cnt, 0);
      isValid = 1'b0; run(1);
      isValid = 1'b1; run(3);
      chk("valid_after_reset_cnt", v_cnt, 1);
      chk("valid_after_reset_lat", first_v, 1);
      isValid = 1'b0; run(2);

      // Reset mid-count discards progress; full latency after release.
      PS2Clock = 1'b0; run(7);
      chk("midcount_no_fall", f_cnt, 0);
      Reset = 1'b0;
      #1;
      chk("midcount_async_fall", int'(FallingEdge), 0);
      run(2);
      Reset = 1'b1;
      run(15);
      chk("post_reset_fall_cnt", f_cnt, 1);
      chk("post_reset_fall_lat", first_f, 10);

      // Reset asserted while a strobe is high clears it immediately.
      PS2Clock = 1'b1; run(15);
      chk("pre_async_rise_cnt", r_cnt, 1);
      PS2Clock = 1'b0; run(10);
      chk("pre_async_fall_high", int'(FallingEdge), 1);
      Reset = 1'b0;
      #1;
      chk("async_fall_clear", int'(FallingEdge), 0);
      chk("async_rise_clear", int'(RisingEdge), 0);
      run(2);
      Reset = 1'b1;
      PS2Clock = 1'b1;
      run(15);
      chk("final_idle_strobes", f_cnt + r_cnt + v_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_edge_pulse.md
Name: ps2_edge_pulse

Overview:
Front-end timing block for the PS/2 keyboard path. It synchronises and glitch-filters the asynchronous PS/2 clock and emits single-cycle rising/falling edge strobes in the system Clock domain. It also shortens a level "frame valid" flag into a one-Clock-cycle strobe. The PS/2 frame shifter uses the edge strobes to shift and latch bits; the valid strobe qualifies key-code capture.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the PS2Clock synchroniser chain (legal >= 2).
FILTER_LEN, 8, consecutive equal synchronised samples required before the filtered PS/2 clock level changes (legal >= 1; 1 = no filtering).

Ports:
Clock  input  1  system clock; all state updates on its rising edge.
Reset  input  1  asynchronous, active-low reset (0 = reset).
PS2Clock  input  1  raw, asynchronous PS/2 clock line (idle high).
isValid  input  1  level flag, synchronous to Clock, high while a decoded frame is valid.
FallingEdge  output  1  one-cycle strobe on a filtered PS2Clock 1->0 transition.
RisingEdge  output  1  one-cycle strobe on a filtered PS2Clock 0->1 transition.
Valid  output  1  one-cycle strobe on each 0->1 transition of isValid.

Behaviour:
- Reset (Reset=0, asynchronous): all synchroniser stages = 1, filtered level = 1, filter counter = 0, FallingEdge = RisingEdge = Valid = 0, isValid history register = 1.
- Synchroniser: PS2Clock passes through SYNC_STAGES flops. The last stage is sync_out.
- Filter: counter increments on every Clock edge where sync_out != filtered. It clears to 0 on any edge where they are equal.
- Filter flip: on the edge where sync_out != filtered and the counter == FILTER_LEN-1, filtered toggles and the counter clears.
- Glitches shorter than FILTER_LEN cycles never change filtered.
- Edge outputs are registered. FallingEdge = 1 for exactly the one cycle in which filtered has just become 0; RisingEdge likewise for the cycle in which it has just become 1. Otherwise both are 0, and they are never high together.
- Edge latency: a clean PS2Clock transition, meeting setup before Clock edge 1, produces the strobe visible after edge SYNC_STAGES+FILTER_LEN (10 with defaults).
- Pulse shortener: the history register captures isValid every cycle.
- Valid is registered: Valid = isValid & ~history. Valid is high for exactly one cycle, the cycle after the first edge that samples isValid high.
- Holding isValid high gives no further strobes. Re-arming requires isValid to be sampled low for at least one cycle.
- isValid toggling every cycle (1,0,1,0) gives a Valid strobe for every high sample.
- isValid high through reset release gives no strobe, because history resets to 1. Valid fires only after isValid has been seen low.
- Reset mid-operation: all outputs drop to 0 immediately, asynchronously. Any in-progress filter count is discarded. After release, the filter needs FILTER_LEN samples of 0 before any FallingEdge can occur.
- No combinational path from any input to any output.

Decomposition:
- Shared package ps2_pkg: PS2_IDLE_LEVEL = 1'b1, and default values for SYNC_STAGES and FILTER_LEN, also used by the frame shifter.
- One natural sub-module: ps2_valid_one_shot, containing the isValid history register and the Valid strobe.
- The synchroniser, filter and edge logic stay in the top.

Test Plan:
- Reset held 0 with PS2Clock=1 and isValid=0; release. Expect all outputs 0 for 20 cycles.
- PS2Clock 1->0 held low (defaults). Expect FallingEdge high exactly one cycle, 10 cycles after the change, and RisingEdge stays 0. Then 0->1 gives the mirror RisingEdge pulse at the same latency.
- PS2Clock low glitches of 3 and 7 Clock cycles. Expect no edge strobes and filtered stays 1. A 10-cycle low gives both strobes.
- isValid 0->1 held for 50 cycles. Expect Valid high exactly one cycle, one cycle after the first high sample. Drop for 1 cycle, raise again: expect a second single Valid pulse.
- isValid held 1 across reset assertion and release. Expect Valid = 0 until isValid goes 0 then 1.
- Assert Reset mid-way through a PS2Clock filter count (cycle 5 of 8). Expect outputs cleared immediately. After release with PS2Clock=0, expect FallingEdge exactly SYNC_STAGES+FILTER_LEN cycles later.
